can_bit_sampler: RTL and testbench

- Receive bit-timing and destuffing stage, directly downstream of frame_detect.
- On the sof_detect pulse it hard-synchronises a bit-phase counter to the frame and samples can_rx once per bit at a programmable sample point.
- It soft-resynchronises on recessive-to-dominant edges, bounded by SJW, and removes stuff bits.
- It delivers destuffed bits with a one-cycle valid strobe to the frame decoder and flags stuff errors.

---
 rtl/can_bit_sampler.sv | 210 +++++++++++++++++++++
 tb/tb_can_bit_sampler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : can_bit_sampler
//  Purpose  : CAN receive bit-timing and destuffing stage. Hard-synchronises
//             a bit-phase counter on the sof_detect pulse, samples the bus
//             once per bit at a programmable sample point, soft-resynchronises
//             on recessive-to-dominant edges (bounded by SJW), removes stuff
//             bits and flags stuff violations.
//  Ports    : clk        - system clock
//             rst        - synchronous active-high reset
//             can_rx     - raw CAN bus line (1 = recessive)
//             sof_detect - one-cycle SOF pulse from frame_detect
//             stuff_en   - destuffing enable from the decoder
//             bit_out    - destuffed bit value
//             bit_valid  - one-cycle strobe qualifying bit_out
//             stuff_err  - one-cycle pulse on a stuff violation
//             rx_active  - high while a frame is being sampled
//  Revision : 1.0 - initial release
// ============================================================================
module can_bit_sampler #(
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int BIT_RATE_KBITS = 1000,
  parameter int SAMPLE_PCT     = 75,
  parameter int SJW            = 4,
  parameter int SOF_PHASE      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic can_rx,
  input  logic sof_detect,
  input  logic stuff_en,
  output logic bit_out,
  output logic bit_valid,
  output logic stuff_err,
  output logic rx_active
);

  localparam int BIT_CLKS  = CLK_FREQ_MHZ * 1000 / BIT_RATE_KBITS;
  localparam int SAMPLE_PT = BIT_CLKS * SAMPLE_PCT / 100;
  localparam int CNT_W     = $clog2(BIT_CLKS);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t C_LAST   = cnt_t'(BIT_CLKS - 1);
  localparam cnt_t C_SAMPLE = cnt_t'(SAMPLE_PT);
  localparam cnt_t C_SJW    = cnt_t'(SJW);
  localparam cnt_t C_SOF    = cnt_t'(SOF_PHASE);
  localparam cnt_t C_ONE    = cnt_t'(1);
  localparam logic [2:0] C_RUN_STUFF = 3'd5;
  localparam logic [3:0] C_REC_END   = 4'd11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RX   = 1'b1
  } state_t;

  state_t     state;
  cnt_t       cnt;
  logic [2:0] run;
  logic [3:0] rec_cnt;
  logic       last;
  logic       first;     // next sample is the SOF bit
  logic       resynced;  // a soft resync already happened in this bit

  // Input synchroniser plus one delay stage for edge detection
  logic rx_meta;
  logic rxs;
  logic rxs_d;

  // Combinational decode
  logic       edge_fall;
  logic       do_resync;
  cnt_t       cnt_inc;
  cnt_t       cnt_resync;
  logic       sample_now;
  logic [3:0] rec_next;
  logic       samp_sof;
  logic       samp_stuff;
  logic       samp_viol;
  logic       samp_emit;
  logic       samp_end;

  assign edge_fall = rxs_d & ~rxs;

  always_comb begin
    cnt_inc    = (cnt == C_LAST) ? '0 : cnt + C_ONE;
    cnt_resync = cnt_inc;
    if (cnt < C_SAMPLE) begin
      // Late edge: pull the phase back by at most SJW
      if (cnt > C_SJW) cnt_resync = cnt + C_ONE - C_SJW;
      else             cnt_resync = C_ONE;
    end else begin
      // Early edge: jump forward to the bit start, or by at most SJW
      if ((C_LAST - cnt) < C_SJW) cnt_resync = '0;
      else                        cnt_resync = cnt + C_ONE + C_SJW;
    end
  end

  // Edges at phase 0 or at the sample point never resync
  assign do_resync = (state == RX) && edge_fall && !resynced &&
                     (cnt != '0) && (cnt != C_SAMPLE);

  always_comb begin
    sample_now = (state == RX) && (cnt == C_SAMPLE);
    // Saturating: the frame ends on the 11th recessive sample anyway
    if (!rxs)                     rec_next = '0;
    else if (rec_cnt == C_REC_END) rec_next = C_REC_END;
    else                          rec_next = rec_cnt + 4'd1;
    samp_sof   = stuff_en && first;
    samp_stuff = stuff_en && !first && (run == C_RUN_STUFF);
    samp_viol  = samp_stuff && (rxs == last);
    samp_emit  = !stuff_en || (!first && (run != C_RUN_STUFF));
    samp_end   = samp_emit && (rec_next == C_REC_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      run       <= '0;
      rec_cnt   <= '0;
      last      <= 1'b1;
      first     <= 1'b0;
      resynced  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      rx_meta   <= can_rx;
      rxs       <= rx_meta;
      rxs_d     <= rxs;
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (sof_detect) begin
            // Hard sync: the counter already accounts for upstream latency
            state     <= RX;
            cnt       <= C_SOF;
            rx_active <= 1'b1;
            run       <= '0;
            rec_cnt   <= '0;
            first     <= 1'b1;
            resynced  <= 1'b0;
          end
        end

        RX: begin
          if (do_resync) begin
            cnt      <= cnt_resync;
            resynced <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end

          if (sample_now) begin
            resynced <= 1'b0;
            rec_cnt  <= rec_next;
            if (samp_sof) begin
              first <= 1'b0;
              last  <= rxs;
              run   <= 3'd1;
            end else if (samp_stuff) begin
              if (samp_viol) begin
                stuff_err <= 1'b1;
                rx_active <= 1'b0;
                state     <= IDLE;
                cnt       <= '0;
              end else begin
                last <= rxs;
                run  <= 3'd1;
              end
            end else begin
              bit_out   <= rxs;
              bit_valid <= 1'b1;
              first     <= 1'b0;
              if (stuff_en) begin
                run  <= (rxs == last) ? run + 3'd1 : 3'd1;
                last <= rxs;
              end else begin
                run <= '0;
              end
            end

            // Stuff violation has priority; it never emits so samp_end is 0
            if (samp_end) begin
              rx_active <= 1'b0;
              state     <= IDLE;
              cnt       <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_bit_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_can_bit_sampler
//  Purpose  : Self-checking bench for can_bit_sampler. Bus bits come from
//             per-test tables of {bus value, stuff_en, bit length, expected
//             strobe / error / rx_active, strobe offset}; expectations are
//             queued when a bit is driven and popped when the DUT strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_can_bit_sampler;

  localparam int SOF_PHASE = 3;
  localparam int NOM_OFF   = 78;  // 75 sample point + 2 sync + 1 register

  logic clk = 1'b0;
  logic rst;
  logic can_rx;
  logic sof_detect;
  logic stuff_en;
  logic bit_out;
  logic bit_valid;
  logic stuff_err;
  logic rx_active;

  can_bit_sampler #(
    .CLK_FREQ_MHZ  (100),
    .BIT_RATE_KBITS(1000),
    .SAMPLE_PCT    (75),
    .SJW           (4),
    .SOF_PHASE     (SOF_PHASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .can_rx    (can_rx),
    .sof_detect(sof_detect),
    .stuff_en  (stuff_en),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .stuff_err (stuff_err),
    .rx_active (rx_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic val;
    int   at;    // absolute strobe cycle, -1 = not checked
    logic act;   // rx_active expected in the strobe cycle
  } exp_t;

  typedef struct {
    logic val;
    logic sen;
    int   clks;
    logic ev;    // expect a bit_valid for this bit
    logic ee;    // expect a stuff_err for this bit
    logic act;
    int   off;   // strobe offset from bit start, -1 = not checked
  } vec_t;

  exp_t sb_q[$];
  int   err_q[$];
  exp_t e;
  int   ecyc;

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  function automatic vec_t row(input logic val, input logic sen, input logic ev,
                               input logic ee, input logic act,
                               input int off, input int clks);
    vec_t v;
    v.val = val; v.sen = sen; v.ev = ev; v.ee = ee;
    v.act = act; v.off = off; v.clks = clks;
    return v;
  endfunction

  // Scoreboard side: compare every strobe against the queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bit_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_bit_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("bit_out", int'(bit_out), int'(e.val));
          if (e.at >= 0) check("strobe_cycle", cyc, e.at);
          check("rx_active_at_strobe", int'(rx_active), int'(e.act));
        end
      end
      if (stuff_err) begin
        if (err_q.size() == 0) begin
          check("unexpected_stuff_err", 1, 0);
        end else begin
          ecyc = err_q.pop_front();
          check("stuff_err_cycle", cyc, ecyc);
          check("rx_active_at_stuff_err", int'(rx_active), 0);
        end
      end
    end
  end

  // Called just after a rising edge; drives one bus bit for v.clks clocks
  task automatic send_bit(input vec_t v, input bit sof);
    int bs;
    exp_t x;
    bs = cyc;
    can_rx   = v.val;
    stuff_en = v.sen;
    if (v.ev) begin
      x.val = v.val;
      x.at  = (v.off >= 0) ? bs + v.off : -1;
      x.act = v.act;
      sb_q.push_back(x);
    end
    if (v.ee) err_q.push_back(bs + v.off);
    for (int c = 0; c < v.clks; c++) begin
      sof_detect = sof && (c == SOF_PHASE + 1);
      @(posedge clk);
      #1;
    end
    sof_detect = 1'b0;
  endtask

  task automatic send_frame(input vec_t tbl[$]);
    for (int i = 0; i < tbl.size(); i++) send_bit(tbl[i], i == 0);
  endtask

  task automatic idle(input int n);
    can_rx = 1'b1; sof_detect = 1'b0; stuff_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check("pending_bits", sb_q.size(), 0);
    check("pending_errs", err_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_out"},   int'(bit_out),   0);
    check({tag, "_bit_valid"}, int'(bit_valid), 0);
    check({tag, "_stuff_err"}, int'(stuff_err), 0);
    check({tag, "_rx_active"}, int'(rx_active), 0);
  endtask

  initial begin
    vec_t t_destuff[$];
    vec_t t_err[$];
    vec_t t_phase[$];
    vec_t t_drift[$];
    vec_t t_rst[$];
    vec_t t_tail[$];

    // SOF, 0000, stuff 1, 1, 0 with destuffing; then 11 recessive, no destuff
    t_destuff.push_back(row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOM_OFF, 100));
    for (int i = 0; i < 4; i++)
      t_destuff.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NOM_OFF, 100));
    t_destuff.push_back(row(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NOM_OFF, 100));
    t_destuff.push_back(row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, NOM_OFF, 100));
    t_destuff.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NOM_OFF, 100));
    for (int i = 0; i < 11; i++)
      t_destuff.push_back(row(1'b1, 1'b0, 1'b1, 1'b0, (i != 10), NOM_OFF, 100));

    // SOF, 0000, then a sixth dominant bit: stuff violation
    t_err.push_back(row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOM_OFF, 100));
    for (int i = 0; i < 4; i++)
      t_err.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NOM_OFF, 100));
    t_err.push_back(row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, NOM_OFF, 100));

    // SOF, recessive bit stretched by 10 clocks; the next edge lands at e=10
    t_phase.push_back(row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOM_OFF, 100));
    t_phase.push_back(row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, NOM_OFF, 110));
    // cnt=7 one cycle after the edge cycle (bit start+2): sample 68 later
    t_phase.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3 + 68 + 1, 100));
    for (int i = 0; i < 11; i++)
      t_phase.push_back(row(1'b1, 1'b0, 1'b1, 1'b0, (i != 10), -1, 100));

    // Slow transmitter, 102 clocks/bit, 40 alternating bits, no destuffing
    t_drift.push_back(row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, 102));
    for (int i = 0; i < 40; i++)
      t_drift.push_back(row(((i % 2) == 0), 1'b0, 1'b1, 1'b0, 1'b1, -1, 102));
    for (int i = 0; i < 11; i++)
      t_drift.push_back(row(1'b1, 1'b0, 1'b1, 1'b0, (i != 10), -1, 100));

    // SOF plus 9 alternating bits before the reset hits bit 10
    t_rst.push_back(row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOM_OFF, 100));
    for (int i = 0; i < 9; i++)
      t_rst.push_back(row(((i % 2) == 0), 1'b1, 1'b1, 1'b0, 1'b1, NOM_OFF, 100));
    // Bus activity after the reset; nothing may be strobed
    for (int i = 0; i < 6; i++)
      t_tail.push_back(row(((i % 3) == 0), 1'b1, 1'b0, 1'b0, 1'b0, NOM_OFF, 100));

    // Reset state
    rst = 1'b1; can_rx = 1'b1; sof_detect = 1'b0; stuff_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle(20);

    send_frame(t_destuff);
    idle(300);

    send_frame(t_err);
    idle(300);

    send_bit(t_phase[0], 1'b1);
    send_bit(t_phase[1], 1'b0);
    fork
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        check("cnt_at_late_edge", int'(dut.cnt), 10);
        @(posedge clk);
        #2;
        check("cnt_after_resync", int'(dut.cnt), 7);
      end
    join_none
    for (int i = 2; i < t_phase.size(); i++) send_bit(t_phase[i], 1'b0);
    idle(300);

    send_frame(t_drift);
    idle(300);

    // Reset in the middle of bit 10
    send_frame(t_rst);
    can_rx = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("midframe_reset");
    repeat (70) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < t_tail.size(); i++) send_bit(t_tail[i], 1'b0);
    idle(300);

    // A new SOF restarts reception after the reset
    send_frame(t_err);
    idle(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
